nasti_lite_reg_reader: RTL
==========================

Name: nasti_lite_reg_reader

Overview:
Downstream read-side slave for the NASTI-lite read channel. It accepts one lite AR request at a time, decodes it against a register window, and runs a req/ack cycle on a simple peripheral register bus. It returns a single-beat lite R response, echoing id and user. Out-of-window addresses, misaligned addresses, register-side errors and unresponsive targets are all converted into error responses.

Parameters:
ID_WIDTH, 1, width of the lite id field
ADDR_WIDTH, 8, lite address width
DATA_WIDTH, 32, lite and register data width; only 32 or 64 are legal (elaboration $fatal otherwise)
USER_WIDTH, 1, user field width, must be >0
BASE_ADDR, 0, byte address of the start of the register window
REG_SPACE, 256, window size in bytes; power of two, >= DATA_WIDTH/8
TIMEOUT, 255, cycles to wait for reg_ack before forcing SLVERR; must be >=1

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
lite_ar_id  in  ID_WIDTH  request id
lite_ar_addr  in  ADDR_WIDTH  byte address
lite_ar_prot  in  3  protection (latched, not checked)
lite_ar_qos  in  4  ignored
lite_ar_region  in  4  ignored
lite_ar_user  in  USER_WIDTH  user field
lite_ar_valid  in  1  AR valid
lite_ar_ready  out  1  AR ready
lite_r_id  out  ID_WIDTH  echoed id
lite_r_data  out  DATA_WIDTH  read data
lite_r_resp  out  2  00 OKAY, 10 SLVERR, 11 DECERR
lite_r_user  out  USER_WIDTH  echoed user
lite_r_valid  out  1  R valid
lite_r_ready  in  1  R ready
reg_req  out  1  register read request (level)
reg_addr  out  $clog2(REG_SPACE)  word-aligned offset within the window
reg_ack  in  1  register read complete
reg_rdata  in  DATA_WIDTH  register data, valid with reg_ack
reg_err  in  1  register-side error, valid with reg_ack

Behaviour:
- FSM states IDLE, REQ, RESP. Reset state IDLE.
- Reset values: lite_ar_ready=1, lite_r_valid=0, reg_req=0. lite_r_data, lite_r_resp, lite_r_id, lite_r_user and reg_addr all reset to 0.
- IDLE:
  - lite_ar_ready=1 in IDLE only.
  - On AR handshake, latch id, user and addr.
  - If the address is outside the window (addr < BASE_ADDR or addr >= BASE_ADDR+REG_SPACE, computed in ADDR_WIDTH+1 bits so there is no wrap): go to RESP with resp=11 and data=0.
  - Else if addr[$clog2(DATA_WIDTH/8)-1:0] != 0: go to RESP with resp=10 and data=0.
  - Else: go to REQ with reg_addr = addr-BASE_ADDR.
- REQ:
  - reg_req=1 and held stable; reg_addr is stable.
  - The timeout counter ($clog2(TIMEOUT+1) bits) clears on REQ entry and increments each cycle without ack.
  - On reg_ack: capture reg_rdata; resp = reg_err ? 10 : 00; go to RESP; reg_req drops the next cycle.
  - If the counter reaches TIMEOUT with no ack: resp=10, data=0, go to RESP.
  - If reg_ack arrives in the same cycle the timeout fires, the ack wins.
- RESP:
  - lite_r_valid=1; id, user, data and resp are held stable until lite_r_ready.
  - On the R handshake, go to IDLE. The next AR can be accepted one cycle later (no same-cycle AR acceptance).
- reg_ack in IDLE or RESP is ignored. A late ack arriving after a timeout must not alter the pending response.
- Latency:
  - AR handshake in cycle N gives reg_req=1 in N+1.
  - reg_ack in cycle M gives lite_r_valid=1 in M+1.
  - A decode error gives lite_r_valid=1 in N+1.
- Exactly one outstanding transaction. lite_r_id always equals the id of the accepted AR.
- Reset asserted mid-transaction: immediate return to IDLE, reg_req=0, lite_r_valid=0; the pending response is discarded.

Test Plan:
- BASE_ADDR=0x40, REG_SPACE=64: AR addr 0x48 id=1, reg_ack 3 cycles later with rdata 0xCAFEF00D -> reg_addr=0x08; R: data 0xCAFEF00D, resp 00, id 1, valid one cycle after ack.
- AR addr 0x80 (out of window) -> no reg_req; R resp 11, data 0, valid the cycle after AR handshake.
- AR addr 0x42 (misaligned, DATA_WIDTH=32) -> no reg_req; R resp 10.
- TIMEOUT=4, target never acks -> reg_req high for exactly 4 cycles; R resp 10, data 0; a subsequent stray reg_ack is ignored.
- reg_ack with reg_err=1 in the same cycle the timeout fires -> resp 10 with captured rdata; a separate case with reg_err=0 -> resp 00 (ack wins).
- lite_r_ready held low for 5 cycles, then rstn pulsed -> lite_r_valid=0 and lite_ar_ready=1 after reset; a new AR completes normally.

Source files
------------

// File: rtl/nasti_lite_reg_reader.sv
//------------------------------------------------------------------------------
// Module   : nasti_lite_reg_reader
// Purpose  : NASTI-lite read slave bridging single-beat AR/R transactions onto
//            a req/ack peripheral register bus, with window decode, alignment
//            check, register-side error mapping and an ack timeout.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module nasti_lite_reg_reader #(
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1,
  parameter int BASE_ADDR  = 0,
  parameter int REG_SPACE  = 256,
  parameter int TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rstn,
  // lite AR channel
  input  logic [ID_WIDTH-1:0]           lite_ar_id,
  input  logic [ADDR_WIDTH-1:0]         lite_ar_addr,
  input  logic [2:0]                    lite_ar_prot,
  input  logic [3:0]                    lite_ar_qos,
  input  logic [3:0]                    lite_ar_region,
  input  logic [USER_WIDTH-1:0]         lite_ar_user,
  input  logic                          lite_ar_valid,
  output logic                          lite_ar_ready,
  // lite R channel
  output logic [ID_WIDTH-1:0]           lite_r_id,
  output logic [DATA_WIDTH-1:0]         lite_r_data,
  output logic [1:0]                    lite_r_resp,
  output logic [USER_WIDTH-1:0]         lite_r_user,
  output logic                          lite_r_valid,
  input  logic                          lite_r_ready,
  // peripheral register bus
  output logic                          reg_req,
  output logic [$clog2(REG_SPACE)-1:0]  reg_addr,
  input  logic                          reg_ack,
  input  logic [DATA_WIDTH-1:0]         reg_rdata,
  input  logic                          reg_err
);

  localparam int c_ra_w = $clog2(REG_SPACE);
  localparam int c_lsb  = $clog2(DATA_WIDTH / 8);
  localparam int c_tw   = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_WIDTH:0] c_win_lo  = (ADDR_WIDTH + 1)'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0] c_win_hi  = (ADDR_WIDTH + 1)'(BASE_ADDR + REG_SPACE);
  localparam logic [c_ra_w-1:0]   c_base_lo = c_ra_w'(BASE_ADDR);
  localparam logic [c_tw-1:0]     c_tmo_last = c_tw'(TIMEOUT - 1);

  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // Parameter legality is enforced at elaboration time.
  generate
    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
      $fatal(1, "nasti_lite_reg_reader: DATA_WIDTH must be 32 or 64");
    end
    if (USER_WIDTH < 1) begin : g_bad_user_width
      $fatal(1, "nasti_lite_reg_reader: USER_WIDTH must be > 0");
    end
    if ((REG_SPACE < DATA_WIDTH / 8) || ((REG_SPACE & (REG_SPACE - 1)) != 0)) begin : g_bad_reg_space
      $fatal(1, "nasti_lite_reg_reader: REG_SPACE must be a power of two >= DATA_WIDTH/8");
    end
    if (c_ra_w > ADDR_WIDTH) begin : g_bad_addr_width
      $fatal(1, "nasti_lite_reg_reader: REG_SPACE exceeds the address space");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
      $fatal(1, "nasti_lite_reg_reader: TIMEOUT must be >= 1");
    end
  endgenerate

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [c_tw-1:0]       r_cnt;
  logic [ID_WIDTH-1:0]   r_id;
  logic [USER_WIDTH-1:0] r_user;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic [c_ra_w-1:0]     r_reg_addr;
  logic [2:0]            r_prot;

  logic                  w_ar_fire;
  logic                  w_out_of_win;
  logic                  w_misaligned;
  logic                  w_timeout;
  logic [c_ra_w-1:0]     w_offset;
  logic                  w_unused;

  // Decode is done one bit wider than the address so BASE+SPACE cannot wrap.
  assign w_ar_fire    = (r_state == S_IDLE) && lite_ar_valid;
  assign w_out_of_win = ({1'b0, lite_ar_addr} < c_win_lo) || ({1'b0, lite_ar_addr} >= c_win_hi);
  assign w_misaligned = (lite_ar_addr[c_lsb-1:0] != '0);
  // Only the low bits of the difference matter once the address is in-window.
  assign w_offset     = lite_ar_addr[c_ra_w-1:0] - c_base_lo;
  // Fires on the TIMEOUT-th REQ cycle, so reg_req is high for exactly TIMEOUT cycles.
  assign w_timeout    = (r_cnt == c_tmo_last);
  // QoS/region are ignored and prot is only recorded.
  assign w_unused     = ^{lite_ar_qos, lite_ar_region, r_prot};

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state decision; an ack always takes priority over the timeout.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (lite_ar_valid) begin
          if (w_out_of_win || w_misaligned) w_next_state = S_RESP;
          else                              w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (reg_ack || w_timeout) w_next_state = S_RESP;
      end
      S_RESP: begin
        if (lite_r_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs are pure functions of the state.
  always_comb begin
    lite_ar_ready = 1'b0;
    lite_r_valid  = 1'b0;
    reg_req       = 1'b0;
    case (r_state)
      S_IDLE:  lite_ar_ready = 1'b1;
      S_REQ:   reg_req       = 1'b1;
      S_RESP:  lite_r_valid  = 1'b1;
      default: lite_ar_ready = 1'b0;
    endcase
  end

  // Transaction context, response payload and timeout counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt      <= '0;
      r_id       <= '0;
      r_user     <= '0;
      r_data     <= '0;
      r_resp     <= c_resp_okay;
      r_reg_addr <= '0;
      r_prot     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_ar_fire) begin
            r_id   <= lite_ar_id;
            r_user <= lite_ar_user;
            r_prot <= lite_ar_prot;
            if (w_out_of_win) begin
              r_resp <= c_resp_decerr;
              r_data <= '0;
            end else if (w_misaligned) begin
              r_resp <= c_resp_slverr;
              r_data <= '0;
            end else begin
              r_reg_addr <= w_offset;
            end
          end
        end
        S_REQ: begin
          if (reg_ack) begin
            r_data <= reg_rdata;
            r_resp <= reg_err ? c_resp_slverr : c_resp_okay;
          end else if (w_timeout) begin
            r_data <= '0;
            r_resp <= c_resp_slverr;
          end else begin
            r_cnt <= r_cnt + c_tw'(1);
          end
        end
        default: begin
          // RESP holds the payload; late acks are deliberately ignored here.
        end
      endcase
    end
  end

  assign lite_r_id   = r_id;
  assign lite_r_user = r_user;
  assign lite_r_data = r_data;
  assign lite_r_resp = r_resp;
  assign reg_addr    = r_reg_addr;

endmodule

`default_nettype wire
